// File: rtl/gate_scan_pkg.sv
// Shared types and constants for the 3-input gate truth-table scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gate_scan_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } scan_state_e;

    // Default number of cycles each stimulus vector is held before sampling
    localparam int unsigned SETTLE_CYCLES_DEF = 4;

    // Golden truth table of Y = (A|B)&(~B|C) | ~(~C&B) == ~B|C, bit i <-> {A,B,C}=i
    localparam logic [7:0] EXPECTED_TT = 8'hBB;

    // Number of stimulus vectors in a full scan
    localparam int unsigned NUM_VECTORS = 8;

endpackage : gate_scan_pkg

// File: rtl/scan_settle_timer.sv
// Settle counter for one stimulus vector; raises early/late sample strobes.
// Latency: early strobe at count SETTLE_CYCLES-2, late strobe at SETTLE_CYCLES-1 (count from 0).
// Backpressure: none; counts whenever run_i is high, idles at zero otherwise.
module scan_settle_timer
    import gate_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic early_o,
    output logic late_o
);

    localparam logic [7:0] EARLY_CNT = 8'(SETTLE_CYCLES - 2);
    localparam logic [7:0] LATE_CNT  = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count up while running; wrap to zero after the late strobe or when stopped
    always_comb begin
        cnt_d = 8'd0;
        if (run_i && !late_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign early_o = run_i && (cnt_q == EARLY_CNT);
    assign late_o  = run_i && (cnt_q == LATE_CNT);

endmodule : scan_settle_timer

// File: rtl/gate_tt_scanner.sv
// Drives all 8 {A,B,C} vectors into a gate, samples its response twice per vector, builds tt.
// Latency: done pulses 8*SETTLE_CYCLES+1 cycles after the accepted start.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module gate_tt_scanner
    import gate_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic [7:0]  EXPECTED      = EXPECTED_TT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       match,
    output logic       err_unstable
);

    scan_state_e state_q;
    scan_state_e state_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic [2:0]  stim_q;
    logic [2:0]  stim_d;
    logic [7:0]  tt_q;
    logic [7:0]  tt_d;
    logic        match_q;
    logic        match_d;
    logic        err_q;
    logic        err_d;
    logic        early_q;
    logic        early_d;

    logic        tmr_run;
    logic        early_stb;
    logic        late_stb;

    // Only the settle phase runs the timer, so it sits at zero in IDLE and DONE
    assign tmr_run = (state_q == ST_SETTLE);

    scan_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk_i   (clk),
        .rst_i   (rst),
        .run_i   (tmr_run),
        .early_o (early_stb),
        .late_o  (late_stb)
    );

    // Next-state and datapath update for the scan controller
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tt_d    = tt_q;
        match_d = match_q;
        err_d   = err_q;
        early_d = early_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 3'd0;
                    tt_d    = 8'h00;
                    match_d = 1'b0;
                    err_d   = 1'b0;
                    early_d = 1'b0;
                end
            end

            ST_SETTLE: begin
                if (early_stb) begin
                    early_d = y_in;
                end
                if (late_stb) begin
                    tt_d[idx_q] = y_in;
                    if (y_in != early_q) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == 3'd7) begin
                        // Evaluate match on the final table so it is valid alongside done
                        state_d = ST_DONE;
                        match_d = (tt_d == EXPECTED);
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase

        // Stimulus follows the vector index only while settling
        stim_d = (state_d == ST_SETTLE) ? idx_d : 3'b000;
    end

    // State and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            stim_q  <= 3'b000;
            tt_q    <= 8'h00;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            tt_q    <= tt_d;
            match_q <= match_d;
            err_q   <= err_d;
            early_q <= early_d;
        end
    end

    assign {a_out, b_out, c_out} = stim_q;
    assign busy                  = (state_q == ST_SETTLE);
    assign done                  = (state_q == ST_DONE);
    assign tt                    = tt_q;
    assign match                 = match_q;
    assign err_unstable          = err_q;

endmodule : gate_tt_scanner

// File: tb/tb_gate_tt_scanner.sv
// Bench for gate_tt_scanner: two instances (settle 4 and settle 2) each driving a unit-delay gate model.
// Latency: scoreboard entries carry the expected done latency from the start cycle.
// Backpressure: n/a.
module tb_gate_tt_scanner;

    typedef struct {
        logic [7:0] tt;
        logic       m;
        logic       e;
        int         start_cyc;
        int         lat;
    } sb_item_t;

    logic clk;
    logic rst;
    logic start1;
    logic start2;
    logic a1, b1, c1, y1, busy1, done1, match1, err1;
    logic a2, b2, c2, y2, busy2, done2, match2, err2;
    logic [7:0] tt1;
    logic [7:0] tt2;
    logic y_sel1;
    logic inv1;

    int n_vec;
    int n_err;
    int cyc;

    sb_item_t sb1[$];
    sb_item_t sb2[$];
    sb_item_t it1;
    sb_item_t it2;

    // Gate under scan for instance 1: Y = (A|B)&(~B|C) | ~(~C&B), one time unit per gate
    logic g1_nb, g1_nc, g1_o1, g1_o2, g1_a1, g1_a2, g1_n2, g1_y;
    assign #1 g1_nb = ~b1;
    assign #1 g1_nc = ~c1;
    assign #1 g1_o1 = a1 | b1;
    assign #1 g1_o2 = g1_nb | c1;
    assign #1 g1_a1 = g1_o1 & g1_o2;
    assign #1 g1_a2 = g1_nc & b1;
    assign #1 g1_n2 = ~g1_a2;
    assign #1 g1_y  = g1_a1 | g1_n2;
    assign y1 = (y_sel1 ? 1'b0 : g1_y) ^ inv1;

    // Same gate for instance 2
    logic g2_nb, g2_nc, g2_o1, g2_o2, g2_a1, g2_a2, g2_n2, g2_y;
    assign #1 g2_nb = ~b2;
    assign #1 g2_nc = ~c2;
    assign #1 g2_o1 = a2 | b2;
    assign #1 g2_o2 = g2_nb | c2;
    assign #1 g2_a1 = g2_o1 & g2_o2;
    assign #1 g2_a2 = g2_nc & b2;
    assign #1 g2_n2 = ~g2_a2;
    assign #1 g2_y  = g2_a1 | g2_n2;
    assign y2 = g2_y;

    gate_tt_scanner #(.SETTLE_CYCLES(4), .EXPECTED(8'hBB)) u_dut (
        .clk(clk), .rst(rst), .start(start1),
        .a_out(a1), .b_out(b1), .c_out(c1), .y_in(y1),
        .busy(busy1), .done(done1), .tt(tt1), .match(match1), .err_unstable(err1)
    );

    gate_tt_scanner #(.SETTLE_CYCLES(2), .EXPECTED(8'hBB)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_out(a2), .b_out(b2), .c_out(c2), .y_in(y2),
        .busy(busy2), .done(done2), .tt(tt2), .match(match2), .err_unstable(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop and compare a scoreboard entry whenever an instance reports done
    always @(negedge clk) begin
        if (done1) begin
            if (sb1.size() == 0) begin
                check_eq("dut1_spurious_done", sb1.size(), 1);
            end else begin
                it1 = sb1.pop_front();
                check_eq("dut1_done_lat", cyc - it1.start_cyc, it1.lat);
                check_eq("dut1_tt", tt1, it1.tt);
                check_eq("dut1_match", match1, it1.m);
                check_eq("dut1_err", err1, it1.e);
                check_eq("dut1_busy_in_done", busy1, 0);
            end
        end
        if (done2) begin
            if (sb2.size() == 0) begin
                check_eq("dut2_spurious_done", sb2.size(), 1);
            end else begin
                it2 = sb2.pop_front();
                check_eq("dut2_done_lat", cyc - it2.start_cyc, it2.lat);
                check_eq("dut2_tt", tt2, it2.tt);
                check_eq("dut2_match", match2, it2.m);
                check_eq("dut2_err", err2, it2.e);
            end
        end
    end

    task automatic scan1(input logic [7:0] exp_tt, input logic exp_m, input logic exp_e,
                         input bit restart);
        sb_item_t it;
        @(negedge clk);
        it.tt = exp_tt; it.m = exp_m; it.e = exp_e; it.start_cyc = cyc; it.lat = 8 * 4 + 1;
        sb1.push_back(it);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 8 * 4; k++) begin
            check_eq("dut1_busy", busy1, 1);
            check_eq("dut1_stim", {a1, b1, c1}, 32'(k / 4));
            start1 = (restart && k == 2 * 4 + 1) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("dut1_tt_hold", tt1, exp_tt);
        check_eq("dut1_match_hold", match1, exp_m);
        check_eq("dut1_idle_stim", {a1, b1, c1}, 0);
        check_eq("dut1_idle_busy", busy1, 0);
    endtask

    task automatic scan2(input logic [7:0] exp_tt, input logic exp_m, input logic exp_e);
        sb_item_t it;
        @(negedge clk);
        it.tt = exp_tt; it.m = exp_m; it.e = exp_e; it.start_cyc = cyc; it.lat = 8 * 2 + 1;
        sb2.push_back(it);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 8 * 2; k++) begin
            check_eq("dut2_stim", {a2, b2, c2}, 32'(k / 2));
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vec1(input logic [2:0] v);
        int w;
        w = 0;
        while ({a1, b1, c1} != v && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("dut1_reach_vec", {a1, b1, c1}, v);
    endtask

    // Flip the response only during the late-sample cycle of vector 3
    task automatic glitch1();
        wait_vec1(3'd3);
        repeat (3) @(negedge clk);
        inv1 = 1'b1;
        @(negedge clk);
        inv1 = 1'b0;
    endtask

    initial begin
        int w;
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; y_sel1 = 1'b0; inv1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", {busy1, busy2}, 0);
        check_eq("rst_done", {done1, done2}, 0);
        check_eq("rst_tt", {tt1, tt2}, 0);
        check_eq("rst_flags", {match1, err1, match2, err2}, 0);
        check_eq("rst_stim", {a1, b1, c1, a2, b2, c2}, 0);

        scan1(8'hBB, 1'b1, 1'b0, 1'b0);

        y_sel1 = 1'b1;
        scan1(8'h00, 1'b0, 1'b0, 1'b0);
        y_sel1 = 1'b0;

        fork
            scan1(8'hB3, 1'b0, 1'b1, 1'b0);
            glitch1();
        join

        scan1(8'hBB, 1'b1, 1'b0, 1'b1);

        // Abort a scan in vector 4 with reset
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_vec1(3'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy_done", {busy1, done1}, 0);
        check_eq("midrst_tt", tt1, 0);
        check_eq("midrst_flags", {match1, err1}, 0);
        check_eq("midrst_stim", {a1, b1, c1}, 0);
        scan1(8'hBB, 1'b1, 1'b0, 1'b0);

        scan2(8'hBB, 1'b1, 1'b0);

        w = 0;
        while ((sb1.size() != 0 || sb2.size() != 0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_eq("sb1_drain", sb1.size(), 0);
        check_eq("sb2_drain", sb2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_gate_tt_scanner
